// File: rtl/rrb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rrb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned CHANNELS = 8;

  // Binary index of the set bit in a one-hot vector (0 when no bit is set).
  function automatic int unsigned onehot_to_idx(input logic [63:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rrb_rot_pri_enc.sv
// Combinational rotating priority encoder: search starts at i_ptr and wraps.
module rrb_rot_pri_enc
  import rrb_pkg::*;
#(
  parameter int unsigned channels = CHANNELS,
  parameter int unsigned ID_W     = $clog2(channels)
) (
  input  logic [channels-1:0] i_req,
  input  logic [ID_W-1:0]     i_ptr,
  output logic [channels-1:0] o_win_oh,
  output logic [ID_W-1:0]     o_win_idx,
  output logic                o_any
);

  // First requester at or after i_ptr (modulo channels) wins.
  always_comb begin
    logic        found;
    int unsigned idx;
    o_win_oh = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < channels; k++) begin
      idx = int'(i_ptr) + k;
      if (idx >= channels) idx = idx - channels;
      if (!found && i_req[idx]) begin
        o_win_oh[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign o_any     = |i_req;
  assign o_win_idx = ID_W'(onehot_to_idx(64'(o_win_oh)));

endmodule

// File: rtl/rrb_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until release.
// Optional forced-release timeout enabled by defining RRB_TIMEOUT_EN.
module rrb_arbiter
  import rrb_pkg::*;
#(
  parameter int unsigned channels = CHANNELS,
  parameter int unsigned ID_W     = $clog2(channels),
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [channels-1:0] req,
  input  logic                done,
  output logic [channels-1:0] gnt_one_hot,
  output logic                gnt_valid,
  output logic [ID_W-1:0]     gnt_id,
  output logic                timeout
);

  state_t              r_state, w_nxt_state;
  logic [ID_W-1:0]     r_ptr, w_nxt_ptr;
  logic [channels-1:0] r_gnt, w_nxt_gnt;
  logic [ID_W-1:0]     r_id, w_nxt_id;
  logic                w_release, w_limit, w_new_grant;
  logic [ID_W-1:0]     w_rel_ptr, w_search_ptr;
  logic [channels-1:0] w_win_oh;
  logic [ID_W-1:0]     w_win_idx;
  logic                w_any;

  // Released channel moves to the back of the queue; the search uses the
  // rotated pointer in the same cycle so a new grant needs no idle bubble.
  assign w_rel_ptr    = (r_id == ID_W'(channels - 1)) ? '0 : r_id + 1'b1;
  assign w_release    = (r_state == BUSY) && (done || !req[r_id] || w_limit);
  assign w_search_ptr = w_release ? w_rel_ptr : r_ptr;

  rrb_rot_pri_enc #(
    .channels (channels),
    .ID_W     (ID_W)
  ) u_enc (
    .i_req     (req),
    .i_ptr     (w_search_ptr),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  // Next-state and next-grant selection.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_gnt   = r_gnt;
    w_nxt_id    = r_id;
    w_new_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_nxt_state = BUSY;
          w_nxt_gnt   = w_win_oh;
          w_nxt_id    = w_win_idx;
          w_new_grant = 1'b1;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_nxt_ptr = w_rel_ptr;
          if (w_any) begin
            w_nxt_gnt   = w_win_oh;
            w_nxt_id    = w_win_idx;
            w_new_grant = 1'b1;
          end else begin
            w_nxt_state = IDLE;
            w_nxt_gnt   = '0;
            w_nxt_id    = '0;
          end
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_gnt   = '0;
        w_nxt_id    = '0;
      end
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_ptr   <= w_nxt_ptr;
      r_gnt   <= w_nxt_gnt;
      r_id    <= w_nxt_id;
    end
  end

`ifdef RRB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_timeout;

  assign w_limit = (r_state == BUSY) && (r_hold_cnt == HOLD_LAST);

  // Hold-time counter: restarts on each new grant, counts BUSY cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold_cnt <= '0;
    end else if (w_new_grant) begin
      r_hold_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  // Pulse only when the limit alone forced the release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_limit && !done && req[r_id];
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_cfg;
  assign w_limit      = 1'b0;
  assign timeout      = 1'b0;
  assign w_unused_cfg = ^{32'(MAX_HOLD), w_new_grant};
`endif

  assign gnt_one_hot = r_gnt;
  assign gnt_id      = r_id;
  assign gnt_valid   = (r_state == BUSY);

endmodule

// File: tb/tb_rrb_arbiter.sv
// Self-checking bench for rrb_arbiter against a queue-free behavioural model.
module tb_rrb_arbiter;

  localparam int N    = 8;
  localparam int HOLD = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt_one_hot;
  logic         gnt_valid;
  logic [2:0]   gnt_id;
  logic         timeout;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: granted channel (-1 = none), priority pointer, hold age.
  int m_g    = -1;
  int m_ptr  = 0;
  int m_age  = 0;
  bit m_to   = 0;

  rrb_arbiter #(
    .channels (N),
    .ID_W     (3),
    .MAX_HOLD (HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .gnt_one_hot (gnt_one_hot),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick(input int start, input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  // Apply one clock edge's worth of specification rules to the model.
  function automatic void model_edge(input bit rst_n, input logic [N-1:0] r, input bit d);
    bit limit;
    m_to = 0;
    if (!rst_n) begin
      m_g = -1; m_ptr = 0; m_age = 0;
    end else if (m_g < 0) begin
      m_g   = pick(m_ptr, r);
      m_age = 0;
    end else begin
`ifdef RRB_TIMEOUT_EN
      limit = (m_age == HOLD - 1);
`else
      limit = 0;
`endif
      if (d || !r[m_g] || limit) begin
        m_to  = limit && !d && r[m_g];
        m_ptr = (m_g + 1) % N;
        m_g   = pick(m_ptr, r);
        m_age = 0;
      end else begin
        m_age++;
      end
    end
  endfunction

  task automatic step(input bit rst_n, input logic [N-1:0] r, input bit d, input string tag);
    logic [N-1:0] exp_oh;
    reset = rst_n; req = r; done = d;
    @(posedge clk);
    #1;
    model_edge(rst_n, r, d);
    exp_oh = (m_g < 0) ? '0 : (N'(1) << m_g);
    check({tag, ".oh"},    32'(gnt_one_hot), 32'(exp_oh));
    check({tag, ".valid"}, 32'(gnt_valid),   32'(m_g >= 0));
    check({tag, ".id"},    32'(gnt_id),      (m_g < 0) ? 32'd0 : 32'(m_g));
    check({tag, ".to"},    32'(timeout),     32'(m_to));
  endtask

  initial begin
    reset = 1'b0; req = '0; done = 1'b0;
    #1;

    // Reset holds outputs low despite full request.
    for (int i = 0; i < 3; i++) step(0, 8'hFF, 0, "rst");
    check("rst.oh_const", 32'(gnt_one_hot), 32'h0);
    step(1, 8'hFF, 0, "rst_rel");
    check("rst_rel.oh_const", 32'(gnt_one_hot), 32'h01);

    // Fairness with done every cycle: 1..7,0,1,2 without a gap.
    for (int i = 0; i < 10; i++) begin
      step(1, 8'hFF, 1, "fair");
      check("fair.seq", 32'(gnt_id), 32'((i + 1) % N));
    end

    // Wrap/skip from ch5.
    step(0, 8'h00, 0, "wrap_rst");
    step(1, 8'h20, 0, "wrap_g5");
    step(1, 8'h06, 1, "wrap_g1");
    check("wrap.ch1", 32'(gnt_one_hot), 32'h02);
    step(1, 8'h04, 1, "wrap_g2");
    check("wrap.ch2", 32'(gnt_one_hot), 32'h04);

    // Sole requester keeps winning with no bubble.
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h10, 1, "sole");
      check("sole.oh", 32'(gnt_one_hot), 32'h10);
    end

    // Request drop releases; reset mid-grant clears and resets pointer.
    step(1, 8'h08, 1, "drop_g3");
    step(1, 8'h08, 0, "drop_hold");
    step(1, 8'h41, 0, "drop_g6");
    check("drop.ch6", 32'(gnt_one_hot), 32'h40);
    step(0, 8'h41, 0, "mid_rst");
    check("mid_rst.oh", 32'(gnt_one_hot), 32'h0);
    step(1, 8'h41, 0, "post_rst");
    check("post_rst.ptr0", 32'(gnt_one_hot), 32'h01);

    // Long hold without done (forced release only with the timeout build).
    step(0, 8'h00, 0, "hold_rst");
    for (int i = 0; i < 12; i++) step(1, 8'h03, 0, "hold");

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & N'($urandom);
      if ($urandom_range(0, 5) == 0) r = '0;
      step(($urandom_range(0, 99) != 0), r, ($urandom_range(0, 2) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
